// File: rtl/harmonic_spacing_index_n.sv
// Harmonic spacing index: scores how closely adjacent omega ratios track a target ratio.
// One serial restoring divider is shared by all pairs. Define HSI_PAIR_DEV_EN to build pair_dev.
module harmonic_spacing_index_n #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int N_CH       = 5,
  parameter int GAIN_SHIFT = 2,
  parameter int AVG_SHIFT  = 8,
  parameter int LOCK_ON    = 14746,
  parameter int LOCK_OFF   = 13107,
  parameter int LOCK_HOLD  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic [N_CH*WIDTH-1:0]        omega_flat,
  input  logic [WIDTH-1:0]             target_ratio,
  output logic [WIDTH-1:0]             hsi,
  output logic signed [WIDTH-1:0]      delta_hsi,
  output logic                         harmonic_locked,
  output logic                         hsi_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [(N_CH-1)*WIDTH-1:0]    pair_dev
);

  localparam int P      = N_CH - 1;
  localparam int IDX_W  = $clog2(N_CH);
  localparam int SUM_W  = WIDTH + $clog2(P);
  localparam int DIV_W  = WIDTH + FRAC;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int PROD_W = SUM_W + FRAC + 1;
  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam int INV_P  = (1 << FRAC) / P;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] R_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] DEV_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, ACC, SCORE, UPDATE} state_t;

  function automatic logic [WIDTH-1:0] score_of(input logic [WIDTH-1:0] dev);
    logic [WIDTH+GAIN_SHIFT-1:0] sh;
    sh = (WIDTH+GAIN_SHIFT)'(dev) << GAIN_SHIFT;
    if (sh >= (WIDTH+GAIN_SHIFT)'(ONE)) return '0;
    return ONE - sh[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] hsi_of(input logic [SUM_W-1:0] s);
    logic [PROD_W-1:0] p;
    logic [PROD_W-1:0] q;
    p = PROD_W'(s) * PROD_W'(INV_P);
    q = p >> FRAC;
    return (q > PROD_W'(ONE)) ? ONE : q[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_delta(input logic signed [WIDTH:0] d);
    if (d[WIDTH] != d[WIDTH-1])
      return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return d[WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_hi;
  logic [CNT_W-1:0] div_cnt_q;

  logic signed [WIDTH-1:0] omega_p0 [N_CH];
  logic [WIDTH-1:0]        target_p0;
  logic [DIV_W-1:0]        rem_p1, den_p1;
  logic [WIDTH-1:0]        lo_p1, quo_p1;
  logic                    ovf_p1;
  logic [SUM_W-1:0]        sum_p2;
  logic [WIDTH-1:0]        hsi_next_p2;

  logic [WIDTH-1:0]        hsi_q;
  logic signed [WIDTH-1:0] delta_q;
  logic signed [WIDTH:0]   baseline_p2;
  logic                    seen_q, lock_q, lock_d, valid_q, overrun_q;
  logic [HOLD_W-1:0]       hold_q, hold_d;

  logic signed [WIDTH-1:0] om_lo, om_hi;
  logic [DIV_W-1:0]        num_full, trial;
  logic                    q_bit, pair_bad;
  logic [WIDTH-1:0]        ratio, dev_raw, pair_score;
  logic signed [WIDTH:0]   base_diff, base_ema;

  assign idx_hi   = idx_q + IDX_W'(1);
  assign om_lo    = omega_p0[idx_q];
  assign om_hi    = omega_p0[idx_hi];
  assign num_full = {om_hi, {FRAC{1'b0}}};
  // A set MSB in rem means the shifted trial exceeds any denominator.
  assign trial    = {rem_p1[DIV_W-2:0], lo_p1[WIDTH-1]};
  assign q_bit    = rem_p1[DIV_W-1] | (trial >= den_p1);

  assign pair_bad   = om_lo[WIDTH-1] | (om_lo == '0) | om_hi[WIDTH-1];
  assign ratio      = (ovf_p1 | quo_p1[WIDTH-1]) ? R_MAX : quo_p1;
  assign dev_raw    = (ratio >= target_p0) ? ratio - target_p0 : target_p0 - ratio;
  assign pair_score = pair_bad ? '0 : score_of(dev_raw);

  assign base_diff = $signed({1'b0, hsi_next_p2}) - baseline_p2;
  assign base_ema  = baseline_p2 + (base_diff >>> AVG_SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_en) state_d = LOAD;
      LOAD:    state_d = DIV;
      DIV:     if (div_cnt_q == CNT_W'(WIDTH-1)) state_d = ACC;
      ACC:     state_d = (idx_q == IDX_W'(P-1)) ? SCORE : LOAD;
      SCORE:   state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d = '0;
    lock_d = lock_q;
    if (hsi_next_p2 >= WIDTH'(LOCK_ON))
      hold_d = (hold_q == HOLD_W'(LOCK_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
    if (hsi_next_p2 < WIDTH'(LOCK_OFF))
      lock_d = 1'b0;
    else if (hold_d == HOLD_W'(LOCK_HOLD))
      lock_d = 1'b1;
  end

`ifdef HSI_PAIR_DEV_EN
  logic [WIDTH-1:0]   dev_p1 [P];
  logic [P*WIDTH-1:0] pair_dev_q;
  assign pair_dev = pair_dev_q;
`else
  assign pair_dev = '0;
`endif

  // p0 capture / p1 serial divide / p2 score accumulate
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (clk_en) begin
        for (int c = 0; c < N_CH; c++) omega_p0[c] <= omega_flat[c*WIDTH +: WIDTH];
        target_p0 <= target_ratio;
        sum_p2    <= '0;
      end
      LOAD: begin
        rem_p1 <= DIV_W'(num_full[DIV_W-1:WIDTH]);
        lo_p1  <= num_full[WIDTH-1:0];
        den_p1 <= DIV_W'($unsigned(om_lo));
        ovf_p1 <= DIV_W'(num_full[DIV_W-1:WIDTH]) >= DIV_W'($unsigned(om_lo));
        quo_p1 <= '0;
      end
      DIV: begin
        rem_p1 <= q_bit ? trial - den_p1 : trial;
        quo_p1 <= {quo_p1[WIDTH-2:0], q_bit};
        lo_p1  <= lo_p1 << 1;
      end
      ACC: begin
        sum_p2 <= sum_p2 + SUM_W'(pair_score);
`ifdef HSI_PAIR_DEV_EN
        dev_p1[idx_q] <= pair_bad ? DEV_MAX : dev_raw;
`endif
      end
      SCORE: hsi_next_p2 <= hsi_of(sum_p2);
      default: ;
    endcase
  end

  // p2 -> outputs: baseline, delta and lock hysteresis
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      div_cnt_q   <= '0;
      hsi_q       <= '0;
      delta_q     <= '0;
      baseline_p2 <= '0;
      seen_q      <= 1'b0;
      hold_q      <= '0;
      lock_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef HSI_PAIR_DEV_EN
      pair_dev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == UPDATE);
      if (clk_en && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (clk_en) idx_q <= '0;
        LOAD: div_cnt_q <= '0;
        DIV:  div_cnt_q <= div_cnt_q + CNT_W'(1);
        ACC:  idx_q <= idx_hi;
        UPDATE: begin
          hsi_q  <= hsi_next_p2;
          hold_q <= hold_d;
          lock_q <= lock_d;
          seen_q <= 1'b1;
          if (!seen_q) begin
            baseline_p2 <= $signed({1'b0, hsi_next_p2});
            delta_q     <= '0;
          end else begin
            baseline_p2 <= base_ema;
            delta_q     <= sat_delta(base_diff);
          end
`ifdef HSI_PAIR_DEV_EN
          for (int p = 0; p < P; p++) pair_dev_q[p*WIDTH +: WIDTH] <= dev_p1[p];
`endif
        end
        default: ;
      endcase
    end
  end

  assign hsi             = hsi_q;
  assign delta_hsi       = delta_q;
  assign harmonic_locked = lock_q;
  assign hsi_valid       = valid_q;
  assign busy            = (state_q != IDLE);
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_harmonic_spacing_index_n.sv
// Scoreboard bench for harmonic_spacing_index_n: a ratio-level reference model queues
// expected results at capture; a monitor checks them whenever hsi_valid pulses.
module tb_harmonic_spacing_index_n;
  localparam int WIDTH = 18, FRAC = 14, N_CH = 5, P = N_CH - 1;
  localparam int GAIN_SHIFT = 2, AVG_SHIFT = 8;
  localparam int LOCK_ON = 14746, LOCK_OFF = 13107, LOCK_HOLD = 3;
  localparam int ONE = 1 << FRAC;
  localparam int RMAX = (1 << (WIDTH-1)) - 1;
  localparam int DEVMAX = (1 << WIDTH) - 1;
  localparam int LAT = P * (WIDTH + 2) + 2;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic [N_CH*WIDTH-1:0] omega_flat = '0;
  logic [WIDTH-1:0] target_ratio = '0;
  logic [WIDTH-1:0] hsi;
  logic signed [WIDTH-1:0] delta_hsi;
  logic harmonic_locked, hsi_valid, busy, overrun;
  logic [P*WIDTH-1:0] pair_dev;

  harmonic_spacing_index_n #(
    .WIDTH(WIDTH), .FRAC(FRAC), .N_CH(N_CH), .GAIN_SHIFT(GAIN_SHIFT),
    .AVG_SHIFT(AVG_SHIFT), .LOCK_ON(LOCK_ON), .LOCK_OFF(LOCK_OFF), .LOCK_HOLD(LOCK_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .omega_flat(omega_flat),
    .target_ratio(target_ratio), .hsi(hsi), .delta_hsi(delta_hsi),
    .harmonic_locked(harmonic_locked), .hsi_valid(hsi_valid), .busy(busy),
    .overrun(overrun), .pair_dev(pair_dev)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]        cap;
    logic [WIDTH-1:0]   hsi;
    logic [WIDTH-1:0]   delta;
    logic               lock;
    logic [P*WIDTH-1:0] devs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  longint cyc = 0;
  int cur_om[N_CH];
  int cur_tgt;
  int m_base = 0, m_hold = 0;
  bit m_seen = 0, m_lock = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void chk_true(input string name, input bit ok, input longint act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, required %s", name, act, req);
    end
  endfunction

  // Reference: ratios by plain integer division, then the scoring and tracking rules.
  function automatic void model_push();
    exp_t e;
    longint sum, r;
    int a, b, dev, sc, h, d, step;
    sum = 0;
    e.devs = '0;
    for (int p = 0; p < P; p++) begin
      a = cur_om[p];
      b = cur_om[p+1];
      if (a <= 0 || b < 0) begin
        dev = DEVMAX;
        sc = 0;
      end else begin
        r = (longint'(b) * ONE) / a;
        if (r > RMAX) r = RMAX;
        dev = (int'(r) > cur_tgt) ? int'(r) - cur_tgt : cur_tgt - int'(r);
        sc = ONE - dev * (1 << GAIN_SHIFT);
        if (sc < 0) sc = 0;
      end
      sum += sc;
      e.devs[p*WIDTH +: WIDTH] = dev[WIDTH-1:0];
    end
    h = int'((sum * (ONE / P)) / ONE);
    if (h > ONE) h = ONE;
    if (!m_seen) begin
      d = 0;
      m_base = h;
      m_seen = 1;
    end else begin
      d = h - m_base;
      step = (d >= 0) ? d / (1 << AVG_SHIFT) : -((-d + (1 << AVG_SHIFT) - 1) / (1 << AVG_SHIFT));
      m_base += step;
    end
    if (h >= LOCK_ON) m_hold = (m_hold < LOCK_HOLD) ? m_hold + 1 : LOCK_HOLD;
    else m_hold = 0;
    if (h < LOCK_OFF) m_lock = 0;
    else if (m_hold == LOCK_HOLD) m_lock = 1;
    e.hsi = h[WIDTH-1:0];
    e.delta = d[WIDTH-1:0];
    e.lock = m_lock;
    e.cap = cyc + 1;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && hsi_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got hsi_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc - longint'(mon_e.cap), LAT);
        chk("hsi", hsi, mon_e.hsi);
        chk("delta_hsi", $signed(delta_hsi), $signed(mon_e.delta));
        chk("harmonic_locked", harmonic_locked, mon_e.lock);
        chk("busy_at_valid", busy, 0);
        for (int p = 0; p < P; p++) begin
`ifdef HSI_PAIR_DEV_EN
          chk("pair_dev", pair_dev[p*WIDTH +: WIDTH], mon_e.devs[p*WIDTH +: WIDTH]);
`else
          chk("pair_dev", pair_dev[p*WIDTH +: WIDTH], 0);
`endif
        end
      end
    end
  end

  task automatic set_om(input int a0, input int a1, input int a2, input int a3, input int a4, input int t);
    cur_om[0] = a0; cur_om[1] = a1; cur_om[2] = a2; cur_om[3] = a3; cur_om[4] = a4;
    cur_tgt = t;
  endtask

  task automatic issue();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL issue_wait: got busy=1 after %0d cycles, expected idle", n);
    end
    for (int c = 0; c < N_CH; c++) omega_flat[c*WIDTH +: WIDTH] = cur_om[c][WIDTH-1:0];
    target_ratio = cur_tgt[WIDTH-1:0];
    clk_en = 1'b1;
    model_push();
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_hsi"}, hsi, 0);
    chk({tag, "_delta"}, delta_hsi, 0);
    chk({tag, "_lock"}, harmonic_locked, 0);
    chk({tag, "_valid"}, hsi_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_pair_dev_any"}, longint'(|pair_dev), 0);
  endtask

  task automatic phi();
    set_om(100, 161, 260, 420, 679, 26510);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    phi(); issue();
    chk("busy_after_capture", busy, 1);
    wait_idle();
    chk_true("phi_hsi_min", hsi >= 15000, hsi, ">= 15000");
    chk("lock_after_1", harmonic_locked, 0);
    phi(); issue(); wait_idle();
    chk("lock_after_2", harmonic_locked, 0);
    phi(); issue(); wait_idle();
    chk("lock_after_3", harmonic_locked, 1);

    set_om(111, 161, 260, 420, 679, 26510); issue(); wait_idle();
    chk_true("mid_hsi_range", hsi > LOCK_OFF && hsi < LOCK_ON, hsi, "between thresholds");
    chk("lock_held_mid", harmonic_locked, 1);

    set_om(100, 100, 100, 100, 100, 26510); issue(); wait_idle();
    chk("equal_hsi", hsi, 0);
    chk("lock_cleared", harmonic_locked, 0);

    set_om(0, 161, 260, 420, 679, 26510); issue(); wait_idle();
    chk_true("theta0_hsi_max", hsi <= 12288, hsi, "<= 12288");

    for (int k = 0; k < 50; k++) begin phi(); issue(); end
    wait_idle();
    set_om(100, 100, 100, 100, 100, 26510); issue(); wait_idle();
    chk_true("drop_delta", $signed(delta_hsi) < -12000, $signed(delta_hsi), "< -12000");
    phi(); issue(); wait_idle();
    chk_true("recover_delta", $signed(delta_hsi) > 0, $signed(delta_hsi), "> 0");

    chk("overrun_before", overrun, 0);
    phi(); issue();
    repeat (9) @(negedge clk);
    omega_flat = {N_CH{18'h00400}};
    target_ratio = 18'd1000;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_idle();
    repeat (100) @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    phi(); issue();
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    sb.delete();
    m_seen = 0; m_base = 0; m_hold = 0; m_lock = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("abort_idle_busy", busy, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: for (int c = 0; c < N_CH; c++)
             cur_om[c] = int'($urandom_range(0, DEVMAX)) - (1 << (WIDTH-1));
        1: begin
          cur_om[0] = int'($urandom_range(50, 3000));
          for (int c = 1; c < N_CH; c++) begin
            cur_om[c] = cur_om[c-1] * int'($urandom_range(150, 170)) / 100;
            if (cur_om[c] > RMAX) cur_om[c] = RMAX;
          end
        end
        default: for (int c = 0; c < N_CH; c++) cur_om[c] = int'($urandom_range(0, 500));
      endcase
      cur_tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEVMAX)) : 26510;
      issue();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/harmonic_spacing_index_n.md
# harmonic_spacing_index_n

Parametrised N-channel harmonic spacing index. It measures how closely each adjacent pair of oscillator angular-frequency steps follows a programmable target ratio (default φ), and reduces the result to one Q-format index, a baseline-relative delta and a hysteretic lock flag. It sits after the oscillator bank's omega_dt outputs and feeds the coherence/state-classification logic. It uses a single shared serial divider, so it trades latency for area.

## Interface
- WIDTH, 18: sample width, signed fixed point
- FRAC, 14: fractional bits (ONE = 2^FRAC)
- N_CH, 5: number of frequency channels (≥2); pairs P = N_CH−1
- GAIN_SHIFT, 2: deviation gain; pair score = ONE − (dev << GAIN_SHIFT)
- AVG_SHIFT, 8: baseline EMA shift
- LOCK_ON, 14746: lock set threshold (0.9)
- LOCK_OFF, 13107: lock clear threshold (0.8)
- LOCK_HOLD, 3: consecutive updates ≥ LOCK_ON needed to set lock
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  sample strobe; starts a computation when idle
- omega_flat  in  N_CH*WIDTH  signed omegas; channel 0 in LSBs, ascending band order
- target_ratio  in  WIDTH  target ratio in Q(FRAC), unsigned magnitude, sampled at capture
- hsi  out  WIDTH  index, 0..ONE
- delta_hsi  out  WIDTH  signed hsi − previous baseline
- harmonic_locked  out  1  hysteretic lock
- hsi_valid  out  1  one-cycle pulse when outputs update
- busy  out  1  computation in progress
- overrun  out  1  sticky; clk_en arrived while busy
- pair_dev  out  P*WIDTH  per-pair |ratio − target| (see Configuration)

## Operation
- FSM states: IDLE, LOAD, DIV, ACC, SCORE, UPDATE.
- IDLE: when clk_en=1, capture omega_flat and target_ratio, clear pair index and score sum, then go to LOAD.
- LOAD: set numerator = omega[i+1] << FRAC and denominator = omega[i].
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
- ACC:
  - ratio r_i is saturated to 2^(WIDTH−1)−1.
  - If omega[i] ≤ 0 or omega[i+1] < 0, score_i = 0 and dev_i = max.
  - Otherwise dev_i = |r_i − target|, and score_i = ONE − (dev_i << GAIN_SHIFT), clamped at 0.
  - Add score_i to score_sum. Go to LOAD if i < P−1, else SCORE.
- SCORE: hsi_next = (score_sum × INV_P) >> FRAC, where INV_P = floor(2^FRAC / P) is a localparam. Clamp to [0, ONE].
- UPDATE:
  - delta_hsi = hsi_next − baseline.
  - baseline += (hsi_next − baseline) >>> AVG_SHIFT. On the first update after reset, baseline = hsi_next and delta = 0.
  - Lock logic: a hold counter increments while hsi_next ≥ LOCK_ON (saturates at LOCK_HOLD) and clears otherwise.
  - Lock sets when the counter reaches LOCK_HOLD. Lock clears immediately when hsi_next < LOCK_OFF. Between the thresholds, lock is unchanged.
  - Pulse hsi_valid, then return to IDLE.
- clk_en while not in IDLE is dropped and sets overrun. overrun clears only on reset.
- Inputs are not re-sampled mid-computation.
- Width rules:
  - Divider runs at WIDTH+FRAC bits.
  - score_sum is WIDTH+clog2(P) bits.
  - Product score_sum × INV_P is full width before the shift.
  - delta is saturated to WIDTH.

## Timing
- Reset values: hsi=0, delta_hsi=0, harmonic_locked=0, hsi_valid=0, busy=0, overrun=0, pair_dev=0, baseline=0, hold counter=0, FSM=IDLE.
- Latency: capture edge to hsi_valid edge is L = P·(WIDTH+2)+2 cycles (default 82). All outputs update on the same edge as hsi_valid and hold until the next update.
- busy is high from the cycle after capture through the UPDATE cycle. The earliest next capture is the cycle after hsi_valid.
- rst_n asserted mid-computation aborts immediately to reset values. No hsi_valid is produced for the aborted sample.

## Configuration
- HSI_PAIR_DEV_EN:
  - Defined: per-pair dev_i registers are built, and pair_dev updates with hsi_valid.
  - Undefined: the registers are not built and pair_dev is tied to 0.
  - Scoring is identical in both cases.

## Test plan
- Exact φ set θ=100, α=161, β₁=260, β₂=420, γ=679, target 26510 → hsi ≥ 15000. hsi_valid arrives exactly 82 cycles after capture.
- All omegas 100 (ratio 1.0) → every score is 0, hsi=0, harmonic_locked=0.
- θ=0 with the remaining channels at the φ set → pair 0 scores 0, hsi ≤ 12288, no X values or hang.
- Lock hysteresis: three φ updates → lock=1 on the 3rd hsi_valid, not before. One update with hsi ≈ 13500 keeps lock=1. An all-equal update → lock=0 on that hsi_valid.
- Run 50 φ updates, then one all-equal update → delta_hsi < −12000. Return to φ → delta_hsi > 0.
- Pulse clk_en 10 cycles after capture → overrun=1, exactly one hsi_valid. Deassert rst_n at cycle 40 of a computation → all outputs 0 and no hsi_valid.
